// File: rtl/even_parity_generator.sv
// Even-parity generator: combinational parity bit, registered codeword stage and odd-weight word counter.
// Optional build macro PARITY_ERR_INJ_EN adds err_inj to corrupt the registered parity bit on demand.
module even_parity_generator #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              in_valid,
`ifdef PARITY_ERR_INJ_EN
    input  logic              err_inj,
`endif
    input  logic              cnt_clr,
    output logic              parity_out,
    output logic [DATA_W:0]   code_out,
    output logic              out_valid,
    output logic [CNT_W-1:0]  odd_cnt
);

    logic inj_bit;

    assign parity_out = ^data_in;

`ifdef PARITY_ERR_INJ_EN
    assign inj_bit = in_valid & err_inj;
`else
    assign inj_bit = 1'b0;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                code_out <= {data_in, parity_out ^ inj_bit};
            end
        end
    end

    // Clear wins over a same-cycle increment; the count sticks at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            odd_cnt <= '0;
        end else if (cnt_clr) begin
            odd_cnt <= '0;
        end else if (in_valid && parity_out && (odd_cnt != '1)) begin
            odd_cnt <= odd_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_even_parity_generator.sv
// Self-checking bench for even_parity_generator: directed test-plan vectors plus randomized traffic
// against a behavioural model; a second instance with CNT_W=2 exercises counter saturation.
module tb_even_parity_generator;

    localparam int DW     = 4;
    localparam int CW     = 16;
    localparam int CW_SAT = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [DW-1:0]   data_in;
    logic            in_valid;
    logic            cnt_clr;
    logic            err_inj;
    logic            parity_out, parity_out_s;
    logic [DW:0]     code_out, code_out_s;
    logic            out_valid, out_valid_s;
    logic [CW-1:0]   odd_cnt;
    logic [CW_SAT-1:0] odd_cnt_s;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [DW:0] m_code;
    logic        m_valid;
    int          m_cnt;
    int          m_cnt_s;

    always #5 clk = ~clk;

    even_parity_generator #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .in_valid(in_valid),
`ifdef PARITY_ERR_INJ_EN
        .err_inj(err_inj),
`endif
        .cnt_clr(cnt_clr), .parity_out(parity_out), .code_out(code_out),
        .out_valid(out_valid), .odd_cnt(odd_cnt)
    );

    even_parity_generator #(.DATA_W(DW), .CNT_W(CW_SAT)) dut_sat (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .in_valid(in_valid),
`ifdef PARITY_ERR_INJ_EN
        .err_inj(err_inj),
`endif
        .cnt_clr(cnt_clr), .parity_out(parity_out_s), .code_out(code_out_s),
        .out_valid(out_valid_s), .odd_cnt(odd_cnt_s)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic ref_parity(input logic [DW-1:0] d);
        return logic'($countones(d) % 2);
    endfunction

    task automatic model_reset();
        m_code  = '0;
        m_valid = 1'b0;
        m_cnt   = 0;
        m_cnt_s = 0;
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
        check({tag, ".code_out"},  64'(code_out),  64'(m_code));
        check({tag, ".odd_cnt"},   64'(odd_cnt),   64'(m_cnt));
        check({tag, ".odd_cnt_sat"}, 64'(odd_cnt_s), 64'(m_cnt_s));
    endtask

    // One clock cycle: drive inputs, check combinational parity, clock, update model, check registers.
    task automatic cycle(input logic [DW-1:0] d, input logic v, input logic clr, input logic inj,
                         input string tag);
        logic p;
        data_in  = d;
        in_valid = v;
        cnt_clr  = clr;
        err_inj  = inj;
        #1;
        p = ref_parity(d);
        check({tag, ".parity_out"}, 64'(parity_out), 64'(p));
        @(posedge clk);
        m_valid = v;
        if (v) begin
`ifdef PARITY_ERR_INJ_EN
            m_code = {d, p ^ inj};
`else
            m_code = {d, p};
`endif
        end
        if (clr) begin
            m_cnt   = 0;
            m_cnt_s = 0;
        end else if (v && p) begin
            if (m_cnt < (2 ** CW) - 1)     m_cnt++;
            if (m_cnt_s < (2 ** CW_SAT) - 1) m_cnt_s++;
        end
        #1;
        check_regs(tag);
    endtask

    initial begin
        logic [DW-1:0] vec [6];
        logic          par [6];
        vec = '{4'b1010, 4'b1111, 4'b0000, 4'b0101, 4'b0111, 4'b1000};
        par = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        rst_n = 1'b0; data_in = '0; in_valid = 1'b0; cnt_clr = 1'b0; err_inj = 1'b0;
        model_reset();

        // Combinational parity while held in reset; clocks run with in_valid=1 to prove reset dominates.
        for (int i = 0; i < 6; i++) begin
            data_in  = vec[i];
            in_valid = 1'b1;
            #1;
            check("rst_parity", 64'(parity_out), 64'(par[i]));
            @(posedge clk);
            #1;
            check_regs("in_reset");
        end

        in_valid = 1'b0;
        rst_n    = 1'b1;

        // Registered path
        cycle(4'b1011, 1'b1, 1'b0, 1'b0, "cap");
        check("cap_code_const", 64'(code_out), 64'(5'b10111));
        cycle(4'b0110, 1'b0, 1'b0, 1'b0, "hold");
        check("hold_code_const", 64'(code_out), 64'(5'b10111));
        check("hold_valid_const", 64'(out_valid), 64'(0));

        // Counter: clear, stream, then clear together with an odd word
        cycle(4'b0000, 1'b0, 1'b1, 1'b0, "clr0");
        cycle(4'b0001, 1'b1, 1'b0, 1'b0, "cnt_a");
        cycle(4'b0011, 1'b1, 1'b0, 1'b0, "cnt_b");
        cycle(4'b0111, 1'b1, 1'b0, 1'b0, "cnt_c");
        cycle(4'b1111, 1'b1, 1'b0, 1'b0, "cnt_d");
        check("cnt_stream_const", 64'(odd_cnt), 64'(2));
        cycle(4'b0001, 1'b1, 1'b1, 1'b0, "clr_prio");
        check("clr_prio_const", 64'(odd_cnt), 64'(0));

        // Saturation on the narrow instance
        for (int i = 0; i < 5; i++) cycle(4'b1110, 1'b1, 1'b0, 1'b0, "sat");
        check("sat_const", 64'(odd_cnt_s), 64'(3));
        check("sat_wide_const", 64'(odd_cnt), 64'(5));

        // Asynchronous reset between edges
        cycle(4'b0000, 1'b0, 1'b1, 1'b0, "pre_rst_clr");
        cycle(4'b0100, 1'b1, 1'b0, 1'b0, "pre_rst_a");
        cycle(4'b1101, 1'b1, 1'b0, 1'b0, "pre_rst_b");
        check("pre_rst_cnt_const", 64'(odd_cnt), 64'(2));
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_regs("async_rst");
        #1;
        rst_n = 1'b1;

`ifdef PARITY_ERR_INJ_EN
        cycle(4'b0111, 1'b1, 1'b0, 1'b0, "inj_pre");
        cycle(4'b1100, 1'b1, 1'b0, 1'b1, "inj");
        check("inj_code_const", 64'(code_out), 64'(5'b11001));
        check("inj_cnt_const", 64'(odd_cnt), 64'(1));
`endif

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            cycle(DW'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
                  1'($urandom_range(0, 3) == 0), "rand");
`ifndef PARITY_ERR_INJ_EN
            if (out_valid) check("rand_invariant", 64'(^code_out), 64'(0));
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
